booth_op_sequencer: RTL
=======================

Name: booth_op_sequencer

Overview:
- Front-end stage directly upstream of the 16-bit Booth multiplier datapath/controller pair.
- Accepts multiplicand/multiplier pairs on a valid/ready input port and returns the multiplier to idle.
- Pulses start and time-multiplexes both operands onto the multiplier's shared 16-bit data_in bus in the exact cycles the controller loads M and Q.
- Waits for done, captures the 32-bit product {A,Q} and presents it on a valid/ready output port.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- CNT_W, 6, width of the cycle counter used for the timeout watchdog.
- TIMEOUT, 40, cycles allowed in WAIT before error, used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_mcand  in  WIDTH  multiplicand, loaded into M.
- in_mplier  in  WIDTH  multiplier, loaded into Q.
- mul_restart  out  1  one-cycle pulse returning the multiplier controller to S0.
- mul_start  out  1  start to multiplier controller.
- mul_data  out  WIDTH  drives multiplier data_in.
- mul_done  in  1  multiplier done, level, held until restart.
- mul_prod  in  2*WIDTH  {A,Q} from multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_prod  out  2*WIDTH  captured product.
- out_err  out  1  timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset; all other outputs 0; operand and product registers cleared.
- All outputs are registered. in_ready=1 only in IDLE.
- FSM transitions:
  - IDLE: in_valid&in_ready -> latch mcand/mplier -> RESTART.
  - RESTART: mul_restart=1 for exactly one cycle -> START.
  - START: mul_start=1 for one cycle, mul_data=0 -> LDM.
  - LDM: mul_data=mcand (controller in S1, ldM) -> LDQ.
  - LDQ: mul_data=mplier (controller in S2, ldQ) -> WAIT.
  - WAIT: mul_data=0; counter increments each cycle; mul_done=1 -> capture mul_prod into out_prod -> HOLD.
  - HOLD: out_valid=1, out_prod stable; out_ready=1 -> out_valid=0 next cycle -> IDLE.
- Handshake:
  - Transfer occurs when valid&ready are both high at a rising edge.
  - Sequencer never drops out_valid before acceptance.
  - No new operand is accepted while a result is pending; one operation is in flight at most.
- Latency:
  - Input accept to mul_start is 2 cycles.
  - mul_done high to out_valid high is 1 cycle.
  - Minimum in-to-in throughput is 1 + 4 + multiplier cycles + 1 + output wait.
- Sampling rules:
  - mul_done is sampled only in WAIT; a stale done in other states is ignored.
  - mul_done already high on the first WAIT cycle is a valid completion.
- Counter:
  - CNT_W bits, cleared on entry to WAIT.
  - Saturates at all-ones; it does not wrap.
- Boundary cases:
  - in_valid held high across HOLD: not accepted until IDLE; in_ready=0 in all non-IDLE states.
  - out_ready high before out_valid: ignored.
  - rst_n asserted mid-operation: immediate IDLE; in-flight pair discarded; no out_valid produced.
  - Multiplier state is recovered by the mul_restart of the next operation.
- Width: mul_prod is captured unmodified; no sign processing is done here.

Optional Feature:
- Macro: BOOTH_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT, counter reaching TIMEOUT without mul_done -> out_prod=0, out_err=1, out_valid=1 in HOLD.
  - out_err clears together with out_valid on acceptance.
- Undefined:
  - WAIT waits indefinitely; out_err tied 0; no comparator logic.

Test Plan:
- Basic product: pair (3, 5), out_ready=1, multiplier model returns done after 34 cycles -> mul_data=3 at START+1 and 5 at START+2; out_prod=0x0000000F; out_valid high exactly 1 cycle.
- Negative operands: (0xFFFE, 0x0007), model prod=0xFFFFFFF2 -> out_prod=0xFFFFFFF2 unchanged.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_prod stable; in_ready=0 with in_valid=1 throughout; accept on cycle 11; IDLE next cycle.
- Back-to-back: two pairs offered continuously -> exactly one mul_restart and one mul_start pulse per pair; second mul_start only after the first result is accepted.
- Mid-operation reset: rst_n low for 1 cycle during WAIT -> all outputs 0 asynchronously; a later mul_done is ignored; next pair completes normally.
- Timeout (BOOTH_SEQ_TIMEOUT_EN, TIMEOUT=40): mul_done never asserted -> after 40 WAIT cycles out_valid=1, out_err=1, out_prod=0. Without the macro -> remains in WAIT; out_valid=0.

Source files
------------

// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer
//
// Front end for the 16-bit Booth multiplier datapath/controller pair. It takes
// one multiplicand/multiplier pair at a time on a valid/ready port and sends
// the multiplier back to its idle state. It then pulses start and puts both
// operands onto the multiplier's shared data bus in the two cycles where the
// controller loads M and Q. When done arrives it captures the {A,Q} product
// and holds it on a valid/ready output port until the product is taken.
//
// Optional build macro: BOOTH_SEQ_TIMEOUT_EN
//   defined   : if the WAIT state runs TIMEOUT cycles without mul_done, the
//               sequencer returns product 0 with out_err=1
//   undefined : WAIT has no time limit and out_err is always 0
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand pair valid
//   in_ready     out  sequencer can accept a pair (IDLE only)
//   in_mcand     in   multiplicand, loaded into M
//   in_mplier    in   multiplier, loaded into Q
//   mul_restart  out  one-cycle pulse that returns the controller to S0
//   mul_start    out  start to the multiplier controller
//   mul_data     out  drives the multiplier data_in bus
//   mul_done     in   multiplier done (level, held until restart)
//   mul_prod     in   {A,Q} from the multiplier
//   out_valid    out  product valid
//   out_ready    in   downstream accepts the product
//   out_prod     out  captured product
//   out_err      out  timeout flag
//
// State table
//   state    | meaning
//   IDLE     | in_ready=1, waiting for an operand pair
//   RESTART  | mul_restart pulse, multiplier returns to S0
//   START    | mul_start pulse, data bus 0
//   LDM      | data bus = multiplicand (controller loads M)
//   LDQ      | data bus = multiplier (controller loads Q)
//   WAIT     | waiting for mul_done, watchdog counter running
//   HOLD     | out_valid=1 until out_ready

module booth_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mcand,
    input  logic [WIDTH-1:0]   in_mplier,
    output logic               mul_restart,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_data,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_START,
        S_LDM,
        S_LDQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mcand_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [WIDTH-1:0]   data_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [2*WIDTH-1:0] prod_d;
    logic               err_d;
    logic               accept;
    logic               timeout_hit;

    // in_ready is a registered copy of "state is IDLE", so the handshake
    // can use it directly.
    assign accept = in_valid & in_ready;

`ifdef BOOTH_SEQ_TIMEOUT_EN
    // The counter is 0 in the first WAIT cycle. Comparing against TIMEOUT-1
    // gives exactly TIMEOUT WAIT cycles before the timeout takes effect.
    assign timeout_hit = (cnt >= CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt;
        prod_d     = out_prod;
        err_d      = out_err;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    mcand_d    = in_mcand;
                    mplier_d   = in_mplier;
                    state_next = S_RESTART;
                end
            end
            S_RESTART: state_next = S_START;
            S_START:   state_next = S_LDM;
            S_LDM:     state_next = S_LDQ;
            S_LDQ: begin
                cnt_d      = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // mul_done is only looked at here. A done still asserted
                // from the previous operation is cleared by the restart
                // pulse before this state is reached.
                if (mul_done) begin
                    prod_d     = mul_prod;
                    err_d      = 1'b0;
                    state_next = S_HOLD;
                end else if (timeout_hit) begin
                    prod_d     = '0;
                    err_d      = 1'b1;
                    state_next = S_HOLD;
                end else if (cnt != '1) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    err_d      = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Outputs are registered from the next state, so each output is
        // valid in the same cycle the FSM occupies the matching state.
        if (state_next == S_LDM) begin
            data_d = mcand_d;
        end else if (state_next == S_LDQ) begin
            data_d = mplier_d;
        end else begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            mul_restart <= 1'b0;
            mul_start   <= 1'b0;
            mul_data    <= '0;
            out_valid   <= 1'b0;
            out_prod    <= '0;
            out_err     <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt         <= cnt_d;
            in_ready    <= (state_next == S_IDLE);
            mul_restart <= (state_next == S_RESTART);
            mul_start   <= (state_next == S_START);
            mul_data    <= data_d;
            out_valid   <= (state_next == S_HOLD);
            out_prod    <= prod_d;
            out_err     <= err_d;
        end
    end

endmodule
